// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: three-requester arbiter for a shared 32-bit memory port.
// Requesters: bit 0 fetch, bit 1 load/store, bit 2 writeback.
// Grant, selector and timeout are registered. busy is decoded from the
// state register.
// A grant is held until one of three things happens: done, the granted
// request drops, or the grant has been held for HOLD_MAX cycles.
// Optional feature: define ARB_ROUND_ROBIN_EN to get round-robin winner
// selection. When it is not defined, fixed priority is used (bit 0 > 1 > 2).
module mem_port_arbiter #(
  parameter int unsigned HOLD_MAX = 15  // legal range 1..255
) (
  input  logic       clk,
  input  logic       reset,     // asynchronous, active low
  input  logic [2:0] req,
  input  logic       done,
  output logic [2:0] grant,
  output logic [2:0] selector,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t     r_state, w_state_next;
  logic [2:0] r_grant, w_grant_next;
  logic [2:0] r_sel, w_sel_next;
  logic [7:0] r_cnt, w_cnt_next;
  logic [1:0] r_ptr, w_ptr_next;
  logic       r_timeout, w_timeout_next;

  logic       w_any_req;
  logic       w_cur_req;
  logic       w_hold_hit;
  logic       w_release;
  logic [1:0] w_win_idx;

  assign w_any_req  = |req;
  // Is the current owner still requesting? This is a one-hot mask test,
  // so it does not need to index req with the selector.
  assign w_cur_req  = |(req & r_grant);
  assign w_hold_hit = (r_cnt == 8'(HOLD_MAX - 1));
  assign w_release  = (r_state == S_BUSY) && (done || !w_cur_req || w_hold_hit);

`ifdef ARB_ROUND_ROBIN_EN
  // Winner: the first requester after the last-granted index, going 0->1->2->0.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    w_win_idx = 2'd0;
    case (r_ptr)
      2'd0: begin
        if      (req[1]) w_win_idx = 2'd1;
        else if (req[2]) w_win_idx = 2'd2;
        else             w_win_idx = 2'd0;
      end
      2'd1: begin
        if      (req[2]) w_win_idx = 2'd2;
        else if (req[0]) w_win_idx = 2'd0;
        else             w_win_idx = 2'd1;
      end
      default: begin
        if      (req[0]) w_win_idx = 2'd0;
        else if (req[1]) w_win_idx = 2'd1;
        else             w_win_idx = 2'd2;
      end
    endcase
  end
`else
  // Pointer is kept up to date but does not steer selection in this build.
  logic w_unused_ptr;
  assign w_unused_ptr = ^r_ptr;

  // Winner: fixed priority, fetch > load/store > writeback.
  always_comb begin
    w_win_idx = 2'd0;
    if      (req[0]) w_win_idx = 2'd0;
    else if (req[1]) w_win_idx = 2'd1;
    else if (req[2]) w_win_idx = 2'd2;
  end
`endif

  // Next-state and next-output logic for the IDLE/BUSY controller.
  always_comb begin
    w_state_next   = r_state;
    w_grant_next   = r_grant;
    w_sel_next     = r_sel;
    w_cnt_next     = r_cnt;
    w_ptr_next     = r_ptr;
    w_timeout_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        // done is ignored here; only a request moves us.
        if (w_any_req) begin
          w_state_next = S_BUSY;
          w_grant_next = 3'b001 << w_win_idx;
          w_sel_next   = {1'b0, w_win_idx};
          w_cnt_next   = 8'd0;
          w_ptr_next   = w_win_idx;
        end else begin
          w_grant_next = 3'b000;
          w_sel_next   = 3'b000;
          w_cnt_next   = 8'd0;
        end
      end
      S_BUSY: begin
        if (w_release) begin
          // A forced release pulses timeout only if neither done nor the
          // requester itself ended the transaction on this edge.
          w_timeout_next = w_hold_hit && !done && w_cur_req;
          if (w_any_req) begin
            // Back-to-back hand-off. The released requester is still eligible.
            w_state_next = S_BUSY;
            w_grant_next = 3'b001 << w_win_idx;
            w_sel_next   = {1'b0, w_win_idx};
            w_cnt_next   = 8'd0;
            w_ptr_next   = w_win_idx;
          end else begin
            w_state_next = S_IDLE;
            w_grant_next = 3'b000;
            w_sel_next   = 3'b000;
            w_cnt_next   = 8'd0;
          end
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_grant_next = 3'b000;
        w_sel_next   = 3'b000;
        w_cnt_next   = 8'd0;
      end
    endcase
  end

  // State and registered outputs. Reset clears everything at once and
  // parks the pointer at 2, so the first round-robin grant starts at bit 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_grant   <= 3'b000;
      r_sel     <= 3'b000;
      r_cnt     <= 8'd0;
      r_ptr     <= 2'd2;
      r_timeout <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register sample the values from before this edge.
      r_state   <= w_state_next;
      r_grant   <= w_grant_next;
      r_sel     <= w_sel_next;
      r_cnt     <= w_cnt_next;
      r_ptr     <= w_ptr_next;
      r_timeout <= w_timeout_next;
    end
  end

  assign grant    = r_grant;
  assign selector = r_sel;
  assign busy     = (r_state == S_BUSY);
  assign timeout  = r_timeout;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter HOLD_MAX, default 15, meaning the maximum number of cycles one grant may be held before forced release (legal range 1..255).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port req  input  3  per-requester request: bit 0 fetch, bit 1 load/store, bit 2 writeback.
REQ-005 The block SHALL have port done  input  1  one-cycle pulse from the shared 32-bit port ending the current transaction.
REQ-006 The block SHALL have port grant  output  3  one-hot grant, registered.
REQ-007 The block SHALL have port selector  output  3  select for the 3-way 32-bit datapath mux: 3'b000 = data_0, 3'b001 = data_1, 3'b010 = data_2, registered.
REQ-008 The block SHALL have port busy  output  1  high while any grant is active.
REQ-009 The block SHALL have port timeout  output  1  one-cycle pulse when a grant is forcibly released.

Function
REQ-010 The FSM SHALL have exactly two states: IDLE (no grant) and BUSY (one grant active).
REQ-011 In IDLE with req != 0, the FSM SHALL go to BUSY on the next edge, with grant, selector and busy valid in that same first BUSY cycle (1-cycle request-to-grant latency).
REQ-012 In IDLE with req == 0, the block SHALL hold grant = 3'b000, selector = 3'b000 and busy = 0.
REQ-013 selector SHALL always equal the binary index of the granted bit (grant 3'b001 -> 000, 3'b010 -> 001, 3'b100 -> 010); codes 011..111 SHALL never be driven.
REQ-014 In BUSY, grant SHALL stay constant until one of three release events: done = 1, the granted req bit deasserting, or timeout.
REQ-015 On a release edge with any req bit still set, the block SHALL grant the next winner directly (back-to-back, no idle cycle); otherwise it SHALL return to IDLE.
REQ-016 Arbitration at a release edge SHALL use the req value sampled at that edge, including the requester just released.
REQ-017 A hold counter SHALL clear on every new grant and increment each BUSY cycle; when it reaches HOLD_MAX - 1 with no other release event, the grant SHALL be released on that edge and timeout SHALL be high for the following cycle only.
REQ-018 If done and the timeout condition coincide, the release SHALL count as done and timeout SHALL stay 0.
REQ-019 done in IDLE SHALL be ignored.
REQ-020 The last-granted pointer (2 bits) SHALL update to the winner's index on every grant.

Reset
REQ-021 reset = 0 SHALL immediately, independent of clk, force state IDLE, grant 3'b000, selector 3'b000, busy 0, timeout 0, hold counter 0 and last-granted pointer 2.
REQ-022 Reset asserted mid-transaction SHALL drop the grant without a timeout pulse, and the first post-reset grant SHALL follow REQ-011.

Configuration
REQ-023 With macro ARB_ROUND_ROBIN_EN defined, the winner SHALL be the first requesting index after the last-granted pointer, in cyclic order 0->1->2->0.
REQ-024 Without ARB_ROUND_ROBIN_EN, the winner SHALL be chosen by fixed priority bit 0 > bit 1 > bit 2, and the pointer SHALL be maintained but unused.

Verification
REQ-025 The bench SHALL check: reset released, req = 3'b010 at cycle 0 -> at cycle 1 grant = 3'b010, selector = 3'b001, busy = 1.
REQ-026 The bench SHALL check: req = 3'b111 held, done pulsed every 3 cycles, RR build -> grant sequence 001, 010, 100, 001, with no idle gap between grants.
REQ-027 The bench SHALL check: the same stimulus as REQ-026 on the fixed-priority build -> grant remains 3'b001 on every grant.
REQ-028 The bench SHALL check: HOLD_MAX = 4, req = 3'b100 held, no done -> grant released after 4 BUSY cycles, timeout = 1 for exactly 1 cycle, then grant 3'b100 reissued.
REQ-029 The bench SHALL check: done and the timeout condition in the same cycle -> timeout stays 0.
REQ-030 The bench SHALL check: reset asserted asynchronously mid-BUSY -> grant = 3'b000, selector = 3'b000 and busy = 0 before the next clk edge; first grant after release goes to bit 0 on both builds.
